// File: rtl/des_cbc_ctrl_pkg.sv
// Shared definitions for the DES CBC chaining front-end: block width and controller states.
package des_cbc_ctrl_pkg;

   localparam int unsigned DES_BLK_W = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_KEY,
      ST_KWAIT,
      ST_ISSUE,
      ST_RUN
   } state_t;

endpackage

// File: rtl/des_cbc_ctrl_wdt.sv
// Watchdog for the RUN state: loaded on clr, counts down while en, expire pulses on the
// WDT_CYC-th enabled cycle without a fresh clr.
module des_cbc_wdt #(
   parameter int unsigned WDT_CYC = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam int unsigned CW = $clog2(WDT_CYC + 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= CW'(WDT_CYC - 1);
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_expire = i_en && (r_cnt == '0);

endmodule

// File: rtl/des_cbc_ctrl.sv
// CBC chaining controller in front of a single-block DES core: pre/post XOR with the chain
// register and Krdy/Drdy/Dvld sequencing. Optional CBC-MAC mode under `DES_CBC_MAC_EN.
module des_cbc_ctrl
   import des_cbc_ctrl_pkg::*;
#(
   parameter int unsigned BLK_W   = DES_BLK_W,
   parameter int unsigned WDT_CYC = 32
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic [BLK_W-1:0] key_in,
   input  logic             krdy_in,
   input  logic [BLK_W-1:0] iv_in,
   input  logic             iv_ld,
   input  logic             enc_mode,
   input  logic [BLK_W-1:0] data_in,
   input  logic             data_vld,
`ifdef DES_CBC_MAC_EN
   input  logic             mac_mode,
   input  logic             data_last,
`endif
   output logic             data_rdy,
   output logic [BLK_W-1:0] data_out,
   output logic             out_vld,
   output logic             key_ok,
   output logic             err,
   output logic [BLK_W-1:0] core_din,
   output logic [BLK_W-1:0] core_key,
   output logic             core_drdy,
   output logic             core_krdy,
   output logic             core_enc,
   output logic             core_en,
   input  logic [BLK_W-1:0] core_dout,
   input  logic             core_dvld,
   input  logic             core_kvld,
   input  logic             core_bsy
);

   state_t           r_state, w_nxt;
   logic [BLK_W-1:0] r_chain, r_ct_hold, r_data_out, r_core_din, r_core_key;
   logic             r_out_vld, r_err, r_key_ok, r_enc, r_core_en;
   logic             w_idle, w_accept, w_done, w_abort, w_expire, w_enc, w_out_en;
   logic             w_wdt_clr, w_wdt_en, w_unused_bsy;
   logic [BLK_W-1:0] w_chain, w_chain_nxt;

   assign w_unused_bsy = core_bsy;
   assign w_idle       = (r_state == ST_IDLE);
   assign data_rdy     = w_idle & r_key_ok & ~krdy_in;
   assign w_accept     = data_rdy & data_vld;
   // an IV loaded alongside an accepted block must already seed that block
   assign w_chain      = iv_ld ? iv_in : r_chain;
   assign w_wdt_clr    = (r_state == ST_ISSUE);
   assign w_wdt_en     = (r_state == ST_RUN);

`ifdef DES_CBC_MAC_EN
   logic r_mac, r_last;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_mac  <= 1'b0;
         r_last <= 1'b0;
      end else if (w_accept) begin
         r_mac  <= mac_mode;
         r_last <= data_last;
      end
   end

   assign w_enc       = enc_mode | mac_mode;
   assign w_out_en    = ~r_mac | r_last;
   assign w_chain_nxt = r_mac ? (r_last ? '0 : core_dout) : (r_enc ? core_dout : r_ct_hold);
`else
   assign w_enc       = enc_mode;
   assign w_out_en    = 1'b1;
   assign w_chain_nxt = r_enc ? core_dout : r_ct_hold;
`endif

   des_cbc_wdt #(.WDT_CYC(WDT_CYC)) u_wdt (
      .clk      (CLK),
      .rst_n    (RSTn),
      .i_clr    (w_wdt_clr),
      .i_en     (w_wdt_en),
      .o_expire (w_expire)
   );

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) r_state <= ST_IDLE;
      else       r_state <= w_nxt;
   end

   always_comb begin
      w_nxt     = r_state;
      w_done    = 1'b0;
      w_abort   = 1'b0;
      core_drdy = 1'b0;
      core_krdy = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (krdy_in)       w_nxt = ST_KEY;
            else if (w_accept) w_nxt = ST_ISSUE;
         end
         ST_KEY: begin
            core_krdy = 1'b1;
            w_nxt     = ST_KWAIT;
         end
         ST_KWAIT: begin
            if (core_kvld) w_nxt = ST_IDLE;
         end
         ST_ISSUE: begin
            core_drdy = 1'b1;
            w_nxt     = ST_RUN;
         end
         ST_RUN: begin
            // a result on the final watchdog cycle still wins over the abort
            if (core_dvld) begin
               w_done = 1'b1;
               w_nxt  = ST_IDLE;
            end else if (w_expire) begin
               w_abort = 1'b1;
               w_nxt   = ST_IDLE;
            end
         end
         default: w_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_chain    <= '0;
         r_ct_hold  <= '0;
         r_data_out <= '0;
         r_core_din <= '0;
         r_core_key <= '0;
         r_out_vld  <= 1'b0;
         r_err      <= 1'b0;
         r_key_ok   <= 1'b0;
         r_enc      <= 1'b1;
         r_core_en  <= 1'b0;
      end else begin
         r_core_en <= 1'b1;
         r_out_vld <= 1'b0;
         r_err     <= 1'b0;
         if (w_idle && iv_ld) r_chain <= iv_in;
         if (w_idle && krdy_in) begin
            r_core_key <= key_in;
            r_key_ok   <= 1'b0;
         end
         if ((r_state == ST_KWAIT) && core_kvld) r_key_ok <= 1'b1;
         if (w_accept) begin
            r_enc      <= w_enc;
            r_core_din <= w_enc ? (data_in ^ w_chain) : data_in;
            r_ct_hold  <= data_in;
         end
         if (w_done) begin
            r_chain <= w_chain_nxt;
            if (w_out_en) begin
               r_data_out <= r_enc ? core_dout : (core_dout ^ r_chain);
               r_out_vld  <= 1'b1;
            end
         end
         if (w_abort) r_err <= 1'b1;
      end
   end

   assign data_out = r_data_out;
   assign out_vld  = r_out_vld;
   assign key_ok   = r_key_ok;
   assign err      = r_err;
   assign core_din = r_core_din;
   assign core_key = r_core_key;
   assign core_enc = r_enc;
   assign core_en  = r_core_en;

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// Scoreboard bench for des_cbc_ctrl with a behavioural core (FIPS vectors plus an invertible
// stand-in cipher). Define DES_CBC_MAC_EN to also exercise the CBC-MAC path.
`timescale 1ns/1ps
module tb_des_cbc_ctrl;

   localparam logic [63:0] FIPS_KEY = 64'h0123456789abcdef;
   localparam logic [63:0] FIPS_IV  = 64'h1234567890abcdef;
   localparam logic [63:0] MIXC     = 64'h9e3779b97f4a7c15;

   logic        CLK, RSTn;
   logic [63:0] key_in, iv_in, data_in, data_out, core_din, core_key, core_dout;
   logic        krdy_in, iv_ld, enc_mode, data_vld, data_rdy, out_vld, key_ok, err;
   logic        core_drdy, core_krdy, core_enc, core_en, core_dvld, core_kvld, core_bsy;
`ifdef DES_CBC_MAC_EN
   logic        mac_mode, data_last;
`endif

   des_cbc_ctrl #(.WDT_CYC(32)) dut (
      .CLK(CLK), .RSTn(RSTn), .key_in(key_in), .krdy_in(krdy_in), .iv_in(iv_in), .iv_ld(iv_ld),
      .enc_mode(enc_mode), .data_in(data_in), .data_vld(data_vld),
`ifdef DES_CBC_MAC_EN
      .mac_mode(mac_mode), .data_last(data_last),
`endif
      .data_rdy(data_rdy), .data_out(data_out), .out_vld(out_vld), .key_ok(key_ok), .err(err),
      .core_din(core_din), .core_key(core_key), .core_drdy(core_drdy), .core_krdy(core_krdy),
      .core_enc(core_enc), .core_en(core_en), .core_dout(core_dout), .core_dvld(core_dvld),
      .core_kvld(core_kvld), .core_bsy(core_bsy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic [63:0] pt [3];
   logic [63:0] ct [3];
   logic [63:0] fips_in [3];

   typedef struct { bit is_err; logic [63:0] data; } exp_t;
   exp_t exp_q [$];

   int          n_checks = 0, n_pass = 0;
   logic [63:0] m_chain = '0, m_key = '0;
   int          core_lat = 17;
   bit          core_dead = 0;
   bit          prev_dvld = 0;

   // DES stand-in: known FIPS block pairs under the FIPS key, otherwise an invertible mix.
   function automatic logic [63:0] core_fn(input logic [63:0] x, input logic [63:0] k, input bit enc);
      logic [63:0] t;
      if (k == FIPS_KEY) begin
         for (int i = 0; i < 3; i++) begin
            if (enc && x == fips_in[i]) return ct[i];
            if (!enc && x == ct[i]) return fips_in[i];
         end
      end
      if (enc) begin
         t = x ^ k;
         return {t[56:0], t[63:57]} + MIXC;
      end
      t = x - MIXC;
      return {t[6:0], t[63:7]} ^ k;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
      n_checks++;
      if (got === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, expv);
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s", name);
   endtask

   // behavioural core
   int          kcnt, dcnt;
   logic [63:0] dres;
   assign core_bsy = (dcnt != 0);
   always @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         core_kvld <= 1'b0; core_dvld <= 1'b0; core_dout <= '0;
         kcnt <= 0; dcnt <= 0; dres <= '0;
      end else begin
         core_kvld <= 1'b0;
         core_dvld <= 1'b0;
         if (core_krdy) kcnt <= 3;
         else if (kcnt > 0) begin
            kcnt <= kcnt - 1;
            if (kcnt == 1) core_kvld <= 1'b1;
         end
         if (core_drdy) begin
            dcnt <= core_lat;
            dres <= core_fn(core_din, core_key, core_enc);
         end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1 && !core_dead) begin
               core_dvld <= 1'b1;
               core_dout <= dres;
            end
         end
      end
   end

   // monitor
   always @(negedge CLK) begin
      exp_t e;
      if (RSTn && (out_vld || err)) begin
         if (exp_q.size() == 0) begin
            fail_now($sformatf("unexpected_output out_vld=%0b err=%0b data_out=%h", out_vld, err, data_out));
         end else begin
            e = exp_q.pop_front();
            if (out_vld) begin
               chk("out_kind_not_err", 64'(e.is_err), 64'(0));
               chk("data_out", data_out, e.data);
               chk("out_vld_latency", 64'(prev_dvld), 64'(1));
            end else begin
               chk("err_expected", 64'(e.is_err), 64'(1));
            end
         end
      end
      prev_dvld = core_dvld;
   end

   task automatic load_key(input logic [63:0] k);
      int n;
      key_in  = k;
      krdy_in = 1'b1;
      m_key   = k;
      #1 chk("rdy_low_during_krdy", 64'(data_rdy), 64'(0));
      @(negedge CLK);
      krdy_in = 1'b0;
      n = 0;
      while (!key_ok && n < 30) begin @(negedge CLK); n++; end
      chk("key_ok", 64'(key_ok), 64'(1));
   endtask

   task automatic send_block(input logic [63:0] d, input bit enc, input bit ld, input logic [63:0] iv,
                             input bit mac, input bit last, input bit use_c, input logic [63:0] cval,
                             input bit exp_err);
      int n;
      bit e;
      logic [63:0] r, outv, nchain;
      exp_t x;
      data_in  = d;
      enc_mode = enc;
`ifdef DES_CBC_MAC_EN
      mac_mode  = mac;
      data_last = last;
`endif
      data_vld = 1'b1;
      n = 0;
      while (!data_rdy && n < 100) begin @(negedge CLK); n++; end
      if (!data_rdy) begin
         fail_now("accept_timeout");
         data_vld = 1'b0;
         return;
      end
      iv_ld = ld;
      iv_in = iv;
      if (ld) m_chain = iv;
      e = enc | mac;
      if (e) begin
         r = core_fn(d ^ m_chain, m_key, 1'b1);
         outv = r; nchain = r;
      end else begin
         outv = core_fn(d, m_key, 1'b0) ^ m_chain;
         nchain = d;
      end
      if (mac && last) nchain = '0;
      if (use_c) outv = cval;
      x.is_err = exp_err;
      x.data   = outv;
      if (exp_err || !mac || last) exp_q.push_back(x);
      if (!exp_err) m_chain = nchain;
      @(negedge CLK);
      data_vld = 1'b0;
      iv_ld    = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin @(negedge CLK); n++; end
      if (exp_q.size() != 0) begin
         fail_now($sformatf("drain_timeout pending=%0d", exp_q.size()));
         exp_q.delete();
      end
      @(negedge CLK);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      pt[0] = 64'h4e6f772069732074; pt[1] = 64'h68652074696d6520; pt[2] = 64'h666f7220616c6c20;
      ct[0] = 64'he5c7cdde872bf27c; ct[1] = 64'h43e934008c389c0f; ct[2] = 64'h683788499a7c05f6;
      fips_in[0] = pt[0] ^ FIPS_IV;
      fips_in[1] = pt[1] ^ ct[0];
      fips_in[2] = pt[2] ^ ct[1];
      RSTn = 1'b0; key_in = '0; krdy_in = 0; iv_in = '0; iv_ld = 0; enc_mode = 0;
      data_in = '0; data_vld = 0;
`ifdef DES_CBC_MAC_EN
      mac_mode = 0; data_last = 0;
`endif
      repeat (3) @(negedge CLK);
      chk("rst_data_out", data_out, 64'(0));
      chk("rst_out_vld", 64'(out_vld), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      chk("rst_key_ok", 64'(key_ok), 64'(0));
      chk("rst_data_rdy", 64'(data_rdy), 64'(0));
      chk("rst_core_drdy", 64'(core_drdy), 64'(0));
      chk("rst_core_krdy", 64'(core_krdy), 64'(0));
      chk("rst_core_enc", 64'(core_enc), 64'(1));
      chk("rst_core_en", 64'(core_en), 64'(0));
      chk("rst_core_din", core_din, 64'(0));
      chk("rst_core_key", core_key, 64'(0));
      RSTn = 1'b1;
      @(negedge CLK);
      chk("core_en_after_reset", 64'(core_en), 64'(1));
      data_vld = 1'b1;
      #1 chk("rdy_without_key", 64'(data_rdy), 64'(0));
      data_vld = 1'b0;

      // FIPS CBC encrypt, then decrypt with the same IV
      load_key(FIPS_KEY);
      for (int i = 0; i < 3; i++) send_block(pt[i], 1'b1, i == 0, FIPS_IV, 0, 0, 1'b1, ct[i], 0);
      wait_done();
      for (int i = 0; i < 3; i++) send_block(ct[i], 1'b0, i == 0, FIPS_IV, 0, 0, 1'b1, pt[i], 0);
      wait_done();

      // held data_vld and iv_ld during a running block
      core_lat = 10;
      send_block({$urandom, $urandom}, 1'b1, 0, '0, 0, 0, 0, '0, 0);
      iv_in = {$urandom, $urandom};
      iv_ld = 1'b1;
      data_in = {$urandom, $urandom};
      data_vld = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("rdy_low_while_busy", 64'(data_rdy), 64'(0));
      end
      iv_ld = 1'b0;
      send_block(data_in, 1'b1, 0, '0, 0, 0, 0, '0, 0);
      wait_done();

      // randomized traffic with mode switches, IV reloads and key changes
      for (int b = 0; b < 40; b++) begin
         if ($urandom_range(0, 9) == 0) begin
            wait_done();
            load_key({$urandom, $urandom});
         end
         core_lat = $urandom_range(1, 31);
         send_block({$urandom, $urandom}, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                    {$urandom, $urandom}, 0, 0, 0, '0, 0);
      end
      wait_done();

      // watchdog boundary: result on last allowed cycle, one cycle late, never
      core_lat = 31;
      send_block({$urandom, $urandom}, 1'b1, 0, '0, 0, 0, 0, '0, 0);
      wait_done();
      core_lat = 32;
      send_block({$urandom, $urandom}, 1'b1, 0, '0, 0, 0, 0, '0, 1);
      wait_done();
      core_dead = 1'b1;
      send_block({$urandom, $urandom}, 1'b0, 0, '0, 0, 0, 0, '0, 1);
      cnt = 0;
      while (!err && cnt < 60) begin @(negedge CLK); cnt++; end
      chk("wdt_drdy_to_err_cycles", 64'(cnt), 64'(33));
      wait_done();
      core_dead = 1'b0;
      core_lat  = 5;
      send_block({$urandom, $urandom}, 1'b1, 0, '0, 0, 0, 0, '0, 0);
      wait_done();

      // reset in the middle of RUN
      core_lat = 20;
      send_block({$urandom, $urandom}, 1'b1, 0, '0, 0, 0, 0, '0, 0);
      repeat (5) @(negedge CLK);
      RSTn = 1'b0;
      #1;
      chk("midrst_data_out", data_out, 64'(0));
      chk("midrst_out_vld", 64'(out_vld), 64'(0));
      chk("midrst_key_ok", 64'(key_ok), 64'(0));
      chk("midrst_core_drdy", 64'(core_drdy), 64'(0));
      chk("midrst_core_din", core_din, 64'(0));
      chk("midrst_core_key", core_key, 64'(0));
      chk("midrst_core_enc", 64'(core_enc), 64'(1));
      chk("midrst_core_en", 64'(core_en), 64'(0));
      exp_q.delete();
      m_chain = '0;
      @(negedge CLK);
      RSTn = 1'b1;
      @(negedge CLK);
      data_vld = 1'b1;
      #1 chk("rdy_after_reset_no_key", 64'(data_rdy), 64'(0));
      data_vld = 1'b0;
      load_key({$urandom, $urandom});
      core_lat = 7;
      send_block({$urandom, $urandom}, 1'b1, 0, '0, 0, 0, 0, '0, 0);
      wait_done();

`ifdef DES_CBC_MAC_EN
      // CBC-MAC over the FIPS blocks; enc_mode deliberately low
      load_key(FIPS_KEY);
      core_lat = 17;
      for (int i = 0; i < 3; i++) send_block(pt[i], 1'b0, i == 0, FIPS_IV, 1'b1, i == 2, 1'b1, ct[2], 0);
      wait_done();
      send_block(pt[0], 1'b1, 0, '0, 0, 0, 0, '0, 0);
      wait_done();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
